// File: rtl/pool_feed_pkg.sv
// Shared definitions for the max-pool feed sequencer: pool latency and FSM states.
package pool_feed_pkg;

    // Cycles from the last window beat on up_valid to a valid dn_data at the pool.
    localparam int POOL_LAT = 4;

    // EVEN    : buffer an even row into the line buffer.
    // ODD_TOP : replay the buffered pixel above the current column.
    // ODD_BOT : forward the incoming odd-row pixel.
    typedef enum logic [1:0] {
        EVEN    = 2'd0,
        ODD_TOP = 2'd1,
        ODD_BOT = 2'd2
    } state_t;

endpackage : pool_feed_pkg

// File: rtl/pool_line.sv
// One-row line buffer: simple dual-port RAM, one write port, registered read port.
module pool_line #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: store the even-row pixel at its column.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: registered, so data appears the cycle after the address.
    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

endmodule : pool_line

// File: rtl/pool_feed.sv
// Reorders a row-major feature map into 2x2 stride-2 pool windows and captures
// each window maximum from the pool unit at its fixed latency.
module pool_feed
    import pool_feed_pkg::*;
#(
    parameter int NUM_WIDTH  = 16,
    parameter int MAX_WIDTH  = 256,
    parameter int MAX_HEIGHT = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [$clog2(MAX_WIDTH):0]    cfg_width,
    input  logic [$clog2(MAX_HEIGHT):0]   cfg_height,
    input  logic [NUM_WIDTH-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          pool_restart,
    output logic [NUM_WIDTH-1:0]          pool_data,
    output logic                          pool_valid,
    input  logic [NUM_WIDTH-1:0]          pool_dn_data,
    output logic [NUM_WIDTH-1:0]          res_data,
    output logic                          res_valid,
    output logic                          res_last
);

    localparam int AW = $clog2(MAX_WIDTH);
    localparam int CW = AW + 1;
    localparam int CH = $clog2(MAX_HEIGHT) + 1;

    // Sequencer state and map counters
    state_t          state_reg, state_next;
    logic [CW-1:0]   col_reg, col_next;
    logic [CH-1:0]   row_reg, row_next;
    logic [CW-1:0]   width_reg, width_next;
    logic [CH-1:0]   height_reg, height_next;
    logic [CW-1:0]   eff_width;
    logic [CH-1:0]   eff_height;
    logic            first_beat;
    logic            accept;
    logic            col_end;
    logic            row_end;

    // Registered pool-side outputs plus window/map end markers travelling with them
    logic                 pool_valid_reg, pool_valid_next;
    logic                 pool_restart_reg, pool_restart_next;
    logic [NUM_WIDTH-1:0] pool_data_reg, pool_data_next;
    logic                 pool_last_reg, pool_last_next;
    logic                 pool_end_reg, pool_end_next;

    // Line buffer ports
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [AW-1:0]        rd_addr;
    logic [NUM_WIDTH-1:0] rd_data;

    // Capture pipeline: one stage per cycle of pool latency
    logic [POOL_LAT-1:0]  cap_vld_reg, cap_vld_next;
    logic [POOL_LAT-1:0]  cap_end_reg, cap_end_next;

    logic [NUM_WIDTH-1:0] res_data_reg;
    logic                 res_valid_reg;
    logic                 res_last_reg;

    pool_line #(
        .WIDTH (NUM_WIDTH),
        .DEPTH (MAX_WIDTH)
    ) u_line (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (in_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Handshake and effective geometry; the very first beat of a map uses the live cfg.
    always_comb begin
        first_beat = (state_reg == EVEN) && (col_reg == '0) && (row_reg == '0);
        eff_width  = first_beat ? cfg_width  : width_reg;
        eff_height = first_beat ? cfg_height : height_reg;
        in_ready   = !rst && ((state_reg == EVEN) || (state_reg == ODD_BOT));
        accept     = in_valid && in_ready;
        col_end    = (col_reg == eff_width - CW'(1));
        row_end    = (row_reg == eff_height - CH'(1));
    end

    // Next-state, counter and pool-beat generation.
    always_comb begin
        state_next        = state_reg;
        col_next          = col_reg;
        row_next          = row_reg;
        width_next        = width_reg;
        height_next       = height_reg;
        pool_valid_next   = 1'b0;
        pool_restart_next = 1'b0;
        pool_data_next    = pool_data_reg;
        pool_last_next    = 1'b0;
        pool_end_next     = 1'b0;
        wr_en             = 1'b0;

        case (state_reg)
            EVEN: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (first_beat) begin
                        width_next  = cfg_width;
                        height_next = cfg_height;
                    end
                    if (col_end) begin
                        col_next   = '0;
                        row_next   = row_reg + CH'(1);
                        state_next = ODD_TOP;
                    end else begin
                        col_next = col_reg + CW'(1);
                    end
                end
            end

            ODD_TOP: begin
                // Buffered pixel was addressed last cycle, so rd_data is buf[col] now.
                pool_valid_next   = 1'b1;
                pool_restart_next = ~col_reg[0];
                pool_data_next    = rd_data;
                state_next        = ODD_BOT;
            end

            ODD_BOT: begin
                if (accept) begin
                    pool_valid_next = 1'b1;
                    pool_data_next  = in_data;
                    pool_last_next  = col_reg[0];
                    state_next      = ODD_TOP;
                    if (col_end) begin
                        col_next   = '0;
                        state_next = EVEN;
                        if (row_end) begin
                            row_next      = '0;
                            pool_end_next = 1'b1;
                        end else begin
                            row_next = row_reg + CH'(1);
                        end
                    end else begin
                        col_next = col_reg + CW'(1);
                    end
                end
            end

            default: begin
                state_next = EVEN;
            end
        endcase
    end

    // The read address is the column the next cycle will work on, which
    // prefetches buf[col] ahead of every ODD_TOP cycle.
    assign wr_addr = col_reg[AW-1:0];
    assign rd_addr = col_next[AW-1:0];

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= EVEN;
            col_reg    <= '0;
            row_reg    <= '0;
            width_reg  <= '0;
            height_reg <= '0;
        end else begin
            state_reg  <= state_next;
            col_reg    <= col_next;
            row_reg    <= row_next;
            width_reg  <= width_next;
            height_reg <= height_next;
        end
    end

    // Registered pool-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pool_valid_reg   <= 1'b0;
            pool_restart_reg <= 1'b0;
            pool_data_reg    <= '0;
            pool_last_reg    <= 1'b0;
            pool_end_reg     <= 1'b0;
        end else begin
            pool_valid_reg   <= pool_valid_next;
            pool_restart_reg <= pool_restart_next;
            pool_data_reg    <= pool_data_next;
            pool_last_reg    <= pool_last_next;
            pool_end_reg     <= pool_end_next;
        end
    end

    // Capture shift register: stage 0 loads when the last window beat is on the pool inputs.
    assign cap_vld_next[0] = pool_valid_reg & pool_last_reg;
    assign cap_end_next[0] = pool_valid_reg & pool_end_reg;

    generate
        for (genvar gi = 1; gi < POOL_LAT; gi++) begin : g_cap
            assign cap_vld_next[gi] = cap_vld_reg[gi-1];
            assign cap_end_next[gi] = cap_end_reg[gi-1];
        end
    endgenerate

    // Advance the capture flags; reset flushes any pending window.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_vld_reg <= '0;
            cap_end_reg <= '0;
        end else begin
            cap_vld_reg <= cap_vld_next;
            cap_end_reg <= cap_end_next;
        end
    end

    // Sample the pool maximum when the oldest capture flag matures.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_reg <= 1'b0;
            res_last_reg  <= 1'b0;
            res_data_reg  <= '0;
        end else begin
            res_valid_reg <= cap_vld_reg[POOL_LAT-1];
            res_last_reg  <= cap_vld_reg[POOL_LAT-1] & cap_end_reg[POOL_LAT-1];
            if (cap_vld_reg[POOL_LAT-1]) begin
                res_data_reg <= pool_dn_data;
            end
        end
    end

    assign pool_valid   = pool_valid_reg;
    assign pool_restart = pool_restart_reg;
    assign pool_data    = pool_data_reg;
    assign res_valid    = res_valid_reg;
    assign res_last     = res_last_reg;
    assign res_data     = res_data_reg;

endmodule : pool_feed

// File: tb/tb_pool_feed.sv
// Scoreboard bench for pool_feed with a behavioural max-pool unit attached.
module tb_pool_feed;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [8:0]        cfg_width = 9'd2;
    logic [8:0]        cfg_height = 9'd2;
    logic [15:0]       in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              pool_restart;
    logic [15:0]       pool_data;
    logic              pool_valid;
    logic [15:0]       pool_dn_data;
    logic [15:0]       res_data;
    logic              res_valid;
    logic              res_last;

    always #5 clk = ~clk;

    pool_feed dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_width    (cfg_width),
        .cfg_height   (cfg_height),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .pool_restart (pool_restart),
        .pool_data    (pool_data),
        .pool_valid   (pool_valid),
        .pool_dn_data (pool_dn_data),
        .res_data     (res_data),
        .res_valid    (res_valid),
        .res_last     (res_last)
    );

    // Behavioural pool unit: running signed max, restart reloads, 4-cycle latency.
    logic signed [15:0] pool_acc;
    logic signed [15:0] pool_nv;
    logic signed [15:0] pool_pipe [0:3];
    assign pool_nv = !pool_valid ? pool_acc :
                     pool_restart ? $signed(pool_data) :
                     ($signed(pool_data) > pool_acc ? $signed(pool_data) : pool_acc);
    always @(posedge clk) begin
        pool_acc     <= pool_nv;
        pool_pipe[0] <= pool_nv;
        pool_pipe[1] <= pool_pipe[0];
        pool_pipe[2] <= pool_pipe[1];
        pool_pipe[3] <= pool_pipe[2];
    end
    assign pool_dn_data = pool_pipe[3];

    typedef struct { int d; bit rs; bit last; } beat_t;
    typedef struct { int d; bit last; } res_t;
    beat_t beat_q [$];
    res_t  res_q  [$];
    int    due_q  [$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    logic signed [15:0] img [0:255];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a pool beat or a result.
    always @(negedge clk) begin
        if (mon_en) begin
            if (pool_restart && !pool_valid) chk("restart_without_valid", 1, 0);
            if (pool_valid) begin
                if (beat_q.size() == 0) begin
                    chk("unexpected_pool_beat", int'($signed(pool_data)), -99999);
                end else begin
                    beat_t e;
                    e = beat_q.pop_front();
                    chk("pool_data", int'($signed(pool_data)), e.d);
                    chk("pool_restart", int'(pool_restart), int'(e.rs));
                    if (e.last) due_q.push_back(cyc + 5);
                    $display("beat cyc=%0d data=%0d restart=%0d", cyc, $signed(pool_data), pool_restart);
                end
            end
            if (res_valid) begin
                if (res_q.size() == 0 || due_q.size() == 0) begin
                    chk("unexpected_res_valid", int'($signed(res_data)), -99999);
                end else begin
                    res_t r;
                    int due;
                    r = res_q.pop_front();
                    due = due_q.pop_front();
                    chk("res_data", int'($signed(res_data)), r.d);
                    chk("res_last", int'(res_last), int'(r.last));
                    chk("res_timing", cyc, due);
                    $display("result cyc=%0d data=%0d last=%0d", cyc, $signed(res_data), res_last);
                end
            end
        end
    end

    // Reference: window order and maxima straight from the 2x2 stride-2 definition.
    task automatic model_map(input int w, input int h);
        for (int r = 0; r < h; r += 2) begin
            for (int x = 0; x < w / 2; x++) begin
                int v [4];
                int m;
                v[0] = img[r*w + 2*x];
                v[1] = img[(r+1)*w + 2*x];
                v[2] = img[r*w + 2*x + 1];
                v[3] = img[(r+1)*w + 2*x + 1];
                m = v[0];
                for (int k = 0; k < 4; k++) begin
                    beat_q.push_back('{d: v[k], rs: (k == 0), last: (k == 3)});
                    if (v[k] > m) m = v[k];
                end
                res_q.push_back('{d: m, last: (r == h - 2) && (x == w / 2 - 1)});
            end
        end
    endtask

    task automatic push_beat(input logic signed [15:0] x);
        int t;
        bit r;
        in_data  = x;
        in_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            if (r) break;
            t++;
            if (t > 200) begin
                chk("in_ready_timeout", 0, 1);
                break;
            end
        end
    endtask

    // Drive one map; gaps are random idle cycles, stall_at forces a 3-cycle drop.
    task automatic run_map(input int w, input int h, input int gap_pct,
                           input int stall_at, input int max_beats);
        cfg_width  = 9'(w);
        cfg_height = 9'(h);
        model_map(w, h);
        for (int i = 0; i < w * h && i < max_beats; i++) begin
            if (i == stall_at) begin
                in_valid = 1'b0;
                repeat (3) @(posedge clk);
                #1;
            end else if (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            push_beat(img[i]);
        end
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        beat_q.delete();
        res_q.delete();
        due_q.delete();
        mon_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_in_ready", int'(in_ready), 0);
            chk("rst_pool_valid", int'(pool_valid), 0);
            chk("rst_pool_restart", int'(pool_restart), 0);
            chk("rst_pool_data", int'(pool_data), 0);
            chk("rst_res_valid", int'(res_valid), 0);
            chk("rst_res_last", int'(res_last), 0);
            chk("rst_res_data", int'(res_data), 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", int'(in_ready), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic load_map_a();
        int a [8] = '{1, 5, 3, 2, 4, 0, 7, 9};
        for (int i = 0; i < 8; i++) img[i] = 16'(a[i]);
    endtask

    task automatic drain();
        int t = 0;
        while ((beat_q.size() != 0 || res_q.size() != 0 || due_q.size() != 0) && t < 200) begin
            @(posedge clk);
            t++;
        end
        repeat (8) @(posedge clk);
        #1;
        chk("beats_outstanding", beat_q.size(), 0);
        chk("results_outstanding", res_q.size(), 0);
    endtask

    initial begin
        do_reset();

        $display("test: 4x2 directed map");
        load_map_a();
        run_map(4, 2, 0, -1, 1 << 30);
        drain();

        $display("test: signed 2x2 map");
        img[0] = -16'sd3; img[1] = -16'sd1; img[2] = -16'sd7; img[3] = -16'sd2;
        run_map(2, 2, 0, -1, 1 << 30);
        drain();

        $display("test: back-to-back 8x4 map");
        for (int i = 0; i < 32; i++) img[i] = 16'($urandom_range(0, 65535));
        run_map(8, 4, 0, -1, 1 << 30);
        drain();

        $display("test: odd-row stall");
        load_map_a();
        run_map(4, 2, 0, 6, 1 << 30);
        drain();

        $display("test: reset mid odd row");
        load_map_a();
        run_map(4, 2, 0, -1, 6);
        do_reset();
        load_map_a();
        run_map(4, 2, 0, -1, 1 << 30);
        drain();

        $display("test: two consecutive maps");
        load_map_a();
        run_map(4, 2, 0, -1, 1 << 30);
        img[0] = 16'sd10; img[1] = -16'sd20; img[2] = 16'sd30; img[3] = 16'sd5;
        run_map(2, 2, 0, -1, 1 << 30);
        drain();

        $display("test: random maps");
        for (int m = 0; m < 10; m++) begin
            int w = 2 * int'($urandom_range(1, 6));
            int h = 2 * int'($urandom_range(1, 4));
            for (int i = 0; i < w * h; i++) img[i] = 16'($urandom_range(0, 65535));
            run_map(w, h, (m % 2 == 0) ? 30 : 0, -1, 1 << 30);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pool_feed
